// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Issue stage sitting directly in front of the 32-bit ALU.
//
// Decoded ops arrive on a valid/ready interface. The MIPS-style aluop/funct
// pair is translated into the 3-bit ALU function code at push time. Each op
// is then buffered in a small FIFO. The head entry is presented to the ALU
// from storage registers, using its own valid/ready handshake.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream op valid
//   in_ready     queue can accept (low while in reset or full)
//   in_aluop     00=add, 01=sub, 10=use funct, 11=illegal
//   in_funct     function field, used when aluop=10
//   in_a, in_b   32-bit operands
//   in_tag       opaque tag carried with the op
//   out_valid    head entry valid
//   out_ready    execute stage consumes the head
//   alu_a/alu_b  head operands (zero when empty)
//   alu_f        head ALU function code (zero when empty)
//   out_tag      head tag (zero when empty)
//   out_illegal  head op was undecodable (zero when empty)
//   err_cnt      saturating count of accepted illegal ops
//
// Optional feature macro: ALU_ISSUE_ERRCNT_EN
//   When defined, err_cnt counts accepted illegal pushes and saturates at
//   16'hFFFF. When undefined, err_cnt is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module alu_issue_queue #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_aluop,
   input  logic [5:0]       in_funct,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_f,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [15:0]      err_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]      mem_a   [DEPTH];
   logic [31:0]      mem_b   [DEPTH];
   logic [2:0]       mem_f   [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic             mem_ill [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic       push;
   logic       pop;
   logic [2:0] dec_f;
   logic       dec_ill;

   // Ready depends only on reset and the stored count. A pop in the same
   // cycle never frees a slot for a push, so no ready path exists from
   // out_ready back to in_ready.
   assign in_ready  = rst_n && (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Translate aluop/funct into the ALU code. Any undecodable combination
   // becomes 011. The ALU leaves that code unused, so it produces y=0.
   always_comb begin
      dec_f   = 3'b011;
      dec_ill = 1'b1;
      case (in_aluop)
         2'b00: begin dec_f = 3'b010; dec_ill = 1'b0; end
         2'b01: begin dec_f = 3'b110; dec_ill = 1'b0; end
         2'b10: begin
            case (in_funct)
               6'b100000: begin dec_f = 3'b010; dec_ill = 1'b0; end
               6'b100010: begin dec_f = 3'b110; dec_ill = 1'b0; end
               6'b100100: begin dec_f = 3'b000; dec_ill = 1'b0; end
               6'b100101: begin dec_f = 3'b001; dec_ill = 1'b0; end
               6'b101010: begin dec_f = 3'b111; dec_ill = 1'b0; end
               default:   begin dec_f = 3'b011; dec_ill = 1'b1; end
            endcase
         end
         default: begin dec_f = 3'b011; dec_ill = 1'b1; end
      endcase
   end

   // The pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage is not reset. Entries are only observable through the
   // count, and an empty queue forces the head outputs to zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= in_b;
         mem_f[wr_ptr]   <= dec_f;
         mem_tag[wr_ptr] <= in_tag;
         mem_ill[wr_ptr] <= dec_ill;
      end
   end

   assign alu_a       = out_valid ? mem_a[rd_ptr]   : '0;
   assign alu_b       = out_valid ? mem_b[rd_ptr]   : '0;
   assign alu_f       = out_valid ? mem_f[rd_ptr]   : '0;
   assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;
   assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;

`ifdef ALU_ISSUE_ERRCNT_EN
   logic [15:0] err_q;

   // Illegal ops are counted when they are accepted, not when they leave.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (push && dec_ill && (err_q != 16'hFFFF)) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
//
// Self-checking bench for alu_issue_queue. The driver issues ops and pushes
// the expected head entry into a scoreboard queue whenever an op is accepted.
// An independent monitor compares the presented head with the front of that
// queue every cycle and pops it when the execute side consumes it.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [2:0]       f;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_aluop;
   logic [5:0]       in_funct;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_f;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;
   logic [15:0]      err_cnt;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   err_model;

   alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_funct(in_funct),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .out_tag(out_tag), .out_illegal(out_illegal),
      .err_cnt(err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Returns {illegal, f} from the aluop/funct decode table.
   function automatic logic [3:0] refDecode(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return {1'b0, 3'b010};
      if (op == 2'b01) return {1'b0, 3'b110};
      if (op == 2'b10) begin
         if (fn == 6'b100000) return {1'b0, 3'b010};
         if (fn == 6'b100010) return {1'b0, 3'b110};
         if (fn == 6'b100100) return {1'b0, 3'b000};
         if (fn == 6'b100101) return {1'b0, 3'b001};
         if (fn == 6'b101010) return {1'b0, 3'b111};
      end
      return {1'b1, 3'b011};
   endfunction

   function automatic int expectedErr();
`ifdef ALU_ISSUE_ERRCNT_EN
      return (err_model > 65535) ? 65535 : err_model;
`else
      return 0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge. Acceptance is decided
   // from in_ready just before the rising edge. The model is then updated.
   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag, input logic ordy,
                                input logic rst, output logic acc);
      logic [3:0] d;
      exp_t       e;
      @(negedge clk);
      rst_n     = rst;
      in_valid  = v;
      in_aluop  = op;
      in_funct  = fn;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      out_ready = ordy;
      #2;
      acc = v && rst && (in_ready === 1'b1);
      @(posedge clk);
      if (!rst) begin
         sb.delete();
         err_model = 0;
      end else if (acc) begin
         d     = refDecode(op, fn);
         e.a   = a;
         e.b   = b;
         e.f   = d[2:0];
         e.tag = tag;
         e.ill = d[3];
         sb.push_back(e);
         if (d[3]) err_model++;
      end
   endtask

   task automatic idle(input logic ordy, input logic rst);
      logic acc;
      applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, '0, ordy, rst, acc);
   endtask

   // Monitor: runs just after each falling edge, once the driver has settled.
   initial begin
      exp_t cur;
      exp_t prev;
      logic hold;
      hold = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #1;
         cur = {alu_a, alu_b, alu_f, out_tag, out_illegal};
         if (!rst_n) begin
            checkOutput("in_ready_in_reset", 128'(in_ready), 128'(0));
            hold = 1'b0;
         end else begin
            checkOutput("err_cnt", 128'(err_cnt), 128'(expectedErr()));
            checkOutput("in_ready", 128'(in_ready), 128'(sb.size() != DEPTH));
            checkOutput("out_valid", 128'(out_valid), 128'(sb.size() != 0));
            if (hold) checkOutput("head_stable", 128'(cur), 128'(prev));
            if (out_valid === 1'b1 && sb.size() != 0) begin
               checkOutput("head_entry", 128'(cur), 128'(sb[0]));
               if (out_ready) void'(sb.pop_front());
               hold = !out_ready;
               prev = cur;
            end else begin
               checkOutput("empty_head_zero", 128'(cur), 128'(0));
               hold = 1'b0;
            end
         end
      end
   end

   initial begin
      logic       acc;
      logic [5:0] legal [5];
      logic [1:0] op;
      logic [5:0] fn;
      checks    = 0;
      errors    = 0;
      err_model = 0;
      legal[0] = 6'b100000; legal[1] = 6'b100010; legal[2] = 6'b100100;
      legal[3] = 6'b100101; legal[4] = 6'b101010;
      rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; in_funct = '0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;

      // Reset, with a push attempted during reset that must be dropped.
      idle(1'b0, 1'b0);
      applyStimulus(1'b1, 2'b00, 6'd0, 32'h11, 32'h22, 5'd3, 1'b0, 1'b0, acc);
      checkOutput("push_during_reset", 128'(acc), 128'(0));
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      #1;
      checkOutput("idle_out_valid", 128'(out_valid), 128'(0));
      checkOutput("idle_in_ready", 128'(in_ready), 128'(1));
      checkOutput("idle_alu_f", 128'(alu_f), 128'(0));
      checkOutput("idle_err_cnt", 128'(err_cnt), 128'(0));

      // Single SLT op shows up one cycle later.
      applyStimulus(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFE, 32'd1, 5'd7, 1'b0, 1'b1, acc);
      #1;
      checkOutput("single_out_valid", 128'(out_valid), 128'(1));
      checkOutput("single_alu_f", 128'(alu_f), 128'(3'b111));
      checkOutput("single_alu_a", 128'(alu_a), 128'(32'hFFFF_FFFE));
      checkOutput("single_alu_b", 128'(alu_b), 128'(1));
      checkOutput("single_tag", 128'(out_tag), 128'(7));
      checkOutput("single_illegal", 128'(out_illegal), 128'(0));
      idle(1'b1, 1'b1);

      // Fill under back-pressure. Then pop while full, which must not push.
      applyStimulus(1'b1, 2'b00, 6'd0, 32'd3, 32'd4, 5'd1, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 2'b10, 6'b100101, 32'hF0, 32'h0F, 5'd2, 1'b0, 1'b1, acc);
      #1;
      checkOutput("full_in_ready", 128'(in_ready), 128'(0));
      applyStimulus(1'b1, 2'b01, 6'd0, 32'd9, 32'd9, 5'd3, 1'b0, 1'b1, acc);
      checkOutput("full_push_held", 128'(acc), 128'(0));
      applyStimulus(1'b1, 2'b01, 6'd0, 32'd9, 32'd9, 5'd3, 1'b1, 1'b1, acc);
      checkOutput("full_pop_no_push", 128'(acc), 128'(0));
      #1;
      checkOutput("after_pop_in_ready", 128'(in_ready), 128'(1));
      checkOutput("after_pop_alu_f", 128'(alu_f), 128'(3'b001));
      idle(1'b1, 1'b1);

      // Streaming: ten back-to-back ops while the consumer is always ready.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 2'b10, legal[$urandom_range(0, 4)], $urandom, $urandom,
                       TAG_W'(i), 1'b1, 1'b1, acc);
         checkOutput("stream_accept", 128'(acc), 128'(1));
      end
      idle(1'b1, 1'b1);

      // Illegal ops, counted at push time.
      idle(1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 6'b000111, 32'd5, 32'd6, 5'd4, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 2'b11, 6'd0, 32'd7, 32'd8, 5'd5, 1'b0, 1'b1, acc);
      #1;
`ifdef ALU_ISSUE_ERRCNT_EN
      checkOutput("illegal_err_cnt", 128'(err_cnt), 128'(2));
`else
      checkOutput("illegal_err_cnt", 128'(err_cnt), 128'(0));
`endif
      checkOutput("illegal_alu_f", 128'(alu_f), 128'(3'b011));
      checkOutput("illegal_flag", 128'(out_illegal), 128'(1));
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Reset with one entry still queued.
      applyStimulus(1'b1, 2'b11, 6'd0, 32'd1, 32'd2, 5'd6, 1'b0, 1'b1, acc);
      idle(1'b0, 1'b0);
      #1;
      checkOutput("midreset_out_valid", 128'(out_valid), 128'(0));
      checkOutput("midreset_err_cnt", 128'(err_cnt), 128'(0));
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         op = 2'($urandom_range(0, 3));
         fn = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 6'($urandom);
         applyStimulus($urandom_range(0, 3) != 0, op, fn, $urandom, $urandom,
                       TAG_W'($urandom), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 59) != 0, acc);
      end

      // Drain with a bounded wait.
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1, 1'b1);
      checkOutput("drain_empty", 128'(sb.size()), 128'(0));
      idle(1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Issue stage directly upstream of the 32-bit ALU (ops AND/OR/ADD/SUB/SLT, 3-bit f code).
- Accepts decoded instructions via valid/ready and translates MIPS-style aluop/funct into the ALU f code.
- Buffers instructions in a small FIFO and presents registered a, b, f to the ALU with an output valid/ready handshake.
- Decouples the decode stage from execute back-pressure.

Parameters:
- DEPTH, 2, FIFO entries (power of two, 2..16).
- TAG_W, 5, width of the opaque tag carried alongside each op (e.g. destination register).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  queue can accept.
- in_aluop  in  2  00=add, 01=sub, 10=use funct, 11=illegal.
- in_funct  in  6  function field.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_tag  in  TAG_W  carried tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute stage consumes head.
- alu_a  out  32  head operand A.
- alu_b  out  32  head operand B.
- alu_f  out  3  head ALU function code.
- out_tag  out  TAG_W  head tag.
- out_illegal  out  1  head op was undecodable.
- err_cnt  out  16  illegal-op counter (see Optional Feature).

Behaviour:
- Reset: synchronous, active-low; takes effect on the rising clk edge while rst_n=0.
  - Clears read/write pointers, count, and all entry valid state.
  - After reset: out_valid=0, alu_a=alu_b=0, alu_f=0, out_tag=0, out_illegal=0, err_cnt=0.
  - in_ready=0 whenever rst_n=0. A push presented in the same cycle as reset is dropped.
- Reset mid-operation discards all queued entries; nothing is emitted afterwards until a new push.
- Decode, performed at push time and stored in the entry:
  - aluop 00 -> f=010 (add).
  - aluop 01 -> f=110 (sub).
  - aluop 10 with funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - aluop 10 with any other funct, or aluop 11 -> f=011 and illegal=1.
  - Code 011 is unused by the ALU, so the ALU outputs y=0 and zero=1 for it.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = rst_n && (count != DEPTH). There is no combinational ready pass-through: when full, a simultaneous pop does not enable a push in the same cycle.
- out_valid = (count != 0). The head fields come straight from storage registers, with no combinational path from any in_* input.
- Latency: a push into an empty queue at edge N gives out_valid=1 after edge N, i.e. one cycle later.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- When empty, alu_a, alu_b, alu_f, out_tag and out_illegal are driven to 0. This makes ALU inputs deterministic: y=0 and zero=1.
- Output stability: while out_valid=1 and out_ready=0, all head outputs hold constant.
- Ordering: strict FIFO. Operand bits and tag pass through unmodified; no arithmetic is performed here.

Optional Feature:
- Macro: ALU_ISSUE_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each accepted push whose decode is illegal.
  - It saturates at 16'hFFFF and is cleared only by reset.
  - Counting happens at push time, independent of when the entry is popped.
- Undefined: err_cnt is tied to 16'h0000 and the counter logic is not built. out_illegal is still produced.

Test Plan:
- Reset then idle:
  - Required: out_valid=0, in_ready=1, alu_f=0, err_cnt=0.
  - Hold rst_n=0 with in_valid=1 -> in_ready=0, and no entry appears after release.
- Single op: push aluop=10, funct=101010, a=32'hFFFF_FFFE, b=1, tag=7.
  - Next cycle: out_valid=1, alu_f=111, alu_a=FFFF_FFFE, alu_b=1, out_tag=7, out_illegal=0.
- Back-pressure fill (DEPTH=2, out_ready=0): push add(a=3, b=4) then OR(a=F0, b=0F).
  - Required: in_ready=0 after the second push; a third in_valid is held and not accepted.
  - Then raise out_ready: entries pop in order, f=010 then f=001.
- Full with simultaneous pop and push: in the cycle out_ready=1 while full, in_ready stays 0.
  - Required: count goes 2 -> 1 and no data is lost or duplicated.
- Streaming wrap-around: 10 back-to-back pushes with out_ready=1 every cycle, tags 0..9.
  - Required: one op emitted per cycle in tag order 0..9, pointers wrap correctly, and in_ready stays 1 throughout.
- Illegal ops:
  - Push aluop=10 funct=000111, then aluop=11 -> both emit alu_f=011, out_illegal=1.
  - With ALU_ISSUE_ERRCNT_EN: err_cnt=2. Without it: err_cnt=0.
  - Apply reset mid-stream with one entry queued -> out_valid=0 and err_cnt=0.
